// File: rtl/flash_read_ctrl.sv
// SPI mode-0 read engine: sends READ command plus address, then shifts in len bytes.
// Uses the externally generated flash_clk (same clk domain) as its bit timebase.
module flash_read_ctrl #(
  parameter logic [7:0]  CMD_READ = 8'h03,
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned LEN_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              clk_en,
  input  logic              flash_clk,
  output logic              flash_cs_n,
  output logic              flash_mosi,
  input  logic              flash_miso
);

  localparam int unsigned TxW  = 8 + ADDR_W;
  localparam int unsigned CntW = $clog2(ADDR_W > 8 ? ADDR_W : 8);

  typedef enum logic [2:0] {StIdle, StSetup, StCmd, StAddr, StData, StFinish} state_e;

  state_e            state_q, state_d;
  logic              fclk_q;
  logic              rise, fall;
  logic [TxW-1:0]    tx_q, tx_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              mosi_q, mosi_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;
  logic              clk_en_q, clk_en_d;

  assign rise = flash_clk & ~fclk_q;
  assign fall = ~flash_clk & fclk_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign clk_en     = clk_en_q;
  assign flash_cs_n = cs_n_q;
  assign flash_mosi = mosi_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    mosi_d     = mosi_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            tx_d       = {CMD_READ, addr};
            mosi_d     = CMD_READ[7];
            byte_cnt_d = len;
            bit_cnt_d  = '0;
            rx_d       = '0;
            state_d    = StSetup;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StSetup: state_d = StCmd;
      StCmd, StAddr: begin
        if (fall) begin
          tx_d   = tx_q << 1;
          mosi_d = tx_q[TxW-2];
        end else if (rise) begin
          if (state_q == StCmd && bit_cnt_q == CntW'(7)) begin
            bit_cnt_d = '0;
            state_d   = StAddr;
          end else if (state_q == StAddr && bit_cnt_q == CntW'(ADDR_W - 1)) begin
            bit_cnt_d = '0;
            mosi_d    = 1'b0;
            state_d   = StData;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (rise) begin
          rx_d = {rx_q[6:0], flash_miso};
          if (bit_cnt_q == CntW'(7)) begin
            bit_cnt_d  = '0;
            rd_data_d  = {rx_q[6:0], flash_miso};
            rd_valid_d = 1'b1;
            byte_cnt_d = byte_cnt_q - LEN_W'(1);
            if (byte_cnt_q == LEN_W'(1)) begin
              state_d = StFinish;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StFinish: begin
        mosi_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Interface outputs are registered from the next state so CS and the clock enable never glitch.
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StFinish);
    cs_n_d   = !(state_d inside {StSetup, StCmd, StAddr, StData});
    clk_en_d = (state_d inside {StCmd, StAddr, StData});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fclk_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      mosi_q     <= 1'b0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      clk_en_q   <= 1'b0;
    end else begin
      fclk_q     <= flash_clk;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      mosi_q     <= mosi_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      clk_en_q   <= clk_en_d;
    end
  end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Bench for flash_read_ctrl: flash_clk generator and flash models, directed transactions,
// scoreboard of expected read bytes.
module tb_flash_read_ctrl;

  localparam logic [7:0] Cmd = 8'h03;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] addr = '0;
  logic [7:0]  len = '0;
  logic        busy, done, rd_valid, clk_en;
  logic [7:0]  rd_data;
  logic        flash_clk;
  logic        flash_cs_n, flash_mosi, flash_miso;

  int checks = 0;
  int errors = 0;

  flash_read_ctrl dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .addr       (addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clk_en     (clk_en),
    .flash_clk  (flash_clk),
    .flash_cs_n (flash_cs_n),
    .flash_mosi (flash_mosi),
    .flash_miso (flash_miso)
  );

  always #5 clk = ~clk;

  // Serial clock generator: half period of two clk cycles, parks low when disabled.
  logic div_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_clk <= 1'b0;
      div_q     <= 1'b0;
    end else if (!clk_en) begin
      flash_clk <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      div_q <= ~div_q;
      if (div_q) flash_clk <= ~flash_clk;
    end
  end

  // Flash model and bus monitor, sampled on the falling clk edge.
  int          total_rises = 0;
  int          outside_rises = 0;
  int          txn_rises = 0;
  int          done_cnt = 0;
  int          cs_rel_cnt = 0;
  int          obs_wr = 0;
  logic [7:0]  obs_arr [0:63];
  logic        fclk_prev = 1'b0;
  logic        cs_prev = 1'b1;
  logic [31:0] cap = '0;
  logic [7:0]  miso_bytes [0:7];

  always @(negedge clk) begin
    if (flash_clk && !fclk_prev) begin
      total_rises++;
      if (flash_cs_n) outside_rises++;
      else begin
        txn_rises++;
        if (txn_rises <= 32) cap = {cap[30:0], flash_mosi};
      end
    end
    if (flash_cs_n) txn_rises = 0;
    if (flash_cs_n && !cs_prev) cs_rel_cnt++;
    if (rd_valid) begin
      obs_arr[obs_wr % 64] = rd_data;
      obs_wr++;
    end
    if (done) done_cnt++;
    fclk_prev = flash_clk;
    cs_prev   = flash_cs_n;
  end

  always_comb begin
    flash_miso = 1'b0;
    if (txn_rises >= 33 && txn_rises < 33 + 64)
      flash_miso = miso_bytes[(txn_rises - 33) / 8][7 - ((txn_rises - 33) % 8)];
  end

  logic [7:0] exp_q [$];
  int         obs_rd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drives start in the current cycle; returns in the idle cycle after done.
  task automatic run_txn(input logic [23:0] a, input logic [7:0] n, input int glitch_at);
    int   base_rises = total_rises;
    int   base_valid = obs_wr;
    int   base_done  = done_cnt;
    int   base_rel   = cs_rel_cnt;
    int   cyc = 0;
    bit   glitched = 1'b0;
    logic [7:0] e;
    start = 1'b1;
    addr  = a;
    len   = n;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(miso_bytes[i]);
    tick();
    start = 1'b0;
    len   = '0;
    if (n != 0) begin
      check("setup_busy", busy, 1);
      check("setup_cs_n", flash_cs_n, 0);
      check("setup_clk_en", clk_en, 0);
      check("setup_mosi", flash_mosi, Cmd[7]);
    end
    while (!done && cyc < 2000) begin
      if (glitch_at != 0 && !glitched && txn_rises == glitch_at) begin
        start = 1'b1;
        addr  = 24'hFFFFFF;
        len   = 8'd5;
        glitched = 1'b1;
      end else begin
        start = 1'b0;
        len   = '0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("done_busy", busy, 1);
    check("done_cs_n", flash_cs_n, 1);
    check("done_clk_en", clk_en, 0);
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("rise_count", total_rises - base_rises, (n == 0) ? 0 : 32 + 8 * int'(n));
    check("valid_count", obs_wr - base_valid, int'(n));
    check("done_count", done_cnt - base_done, 1);
    check("cs_release_count", cs_rel_cnt - base_rel, (n == 0) ? 0 : 1);
    if (n != 0) check("mosi_cmd_addr", cap, {Cmd, a});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_data", obs_arr[obs_rd % 64], e);
      obs_rd++;
    end
    obs_rd = obs_wr;
  endtask

  initial begin
    int base_done;
    int base_valid;
    int cyc;
    for (int i = 0; i < 8; i++) miso_bytes[i] = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_clk_en", clk_en, 0);
    check("rst_cs_n", flash_cs_n, 1);
    check("rst_mosi", flash_mosi, 0);
    rst_n = 1'b1;
    tick();

    miso_bytes[0] = 8'hA5;
    run_txn(24'h123456, 8'd1, 0);

    run_txn(24'h00AAAA, 8'd0, 0);
    check("rd_data_hold", rd_data, 8'hA5);

    miso_bytes[0] = 8'h5A;
    miso_bytes[1] = 8'hC3;
    run_txn(24'h123456, 8'd2, 12);

    // Reset in the middle of the address phase.
    base_done  = done_cnt;
    base_valid = obs_wr;
    start = 1'b1;
    addr  = 24'h0F0F0F;
    len   = 8'd2;
    tick();
    start = 1'b0;
    len   = '0;
    cyc = 0;
    while (txn_rises < 20 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("reset_wait_rises", txn_rises, 20);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", flash_cs_n, 1);
    check("mid_rst_clk_en", clk_en, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_no_done", done_cnt - base_done, 0);
    check("mid_rst_no_valid", obs_wr - base_valid, 0);
    check("mid_rst_rd_data", rd_data, 8'h00);
    obs_rd = obs_wr;

    miso_bytes[0] = 8'h11;
    miso_bytes[1] = 8'h22;
    miso_bytes[2] = 8'h33;
    run_txn(24'h000100, 8'd3, 0);

    // Back-to-back: second start lands in the cycle right after done.
    miso_bytes[0] = 8'h96;
    run_txn(24'h800001, 8'd1, 0);
    miso_bytes[0] = 8'h3C;
    miso_bytes[1] = 8'hE7;
    run_txn(24'h7FFFFE, 8'd2, 0);

    repeat (5) tick();
    check("final_rd_data_hold", rd_data, 8'hE7);
    check("rises_outside_cs", outside_rises, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
